// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-programmable serial bit-pattern detector
// Registered match pulse and saturating match counter.
module seq_detect_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_1000,
   parameter int                 DEF_LEN     = 5,
   parameter bit                 DEF_OVERLAP = 1'b0,
   localparam int                LW          = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   input  logic               x_valid,
   input  logic               x,
   input  logic               cnt_clr,
   output logic               y,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   logic [MAX_LEN-1:0] pat;
   logic [MAX_LEN-1:0] win;
   logic [MAX_LEN-1:0] win_nx;
   logic [MAX_LEN-1:0] mask;
   logic [LW-1:0]      len;
   logic [LW-1:0]      fill;
   logic [LW-1:0]      len_clamp;
   logic [LW:0]        fill_p1;
   logic               ovl;
   logic               shift;
   logic               hit;

   // Decision is made on the incoming bit, so compare against the would-be window.
   always_comb begin
      shift   = x_valid & ~cfg_load;
      win_nx  = {win[MAX_LEN-2:0], x};
      fill_p1 = {1'b0, fill} + {{LW{1'b0}}, 1'b1};
      mask    = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
      hit = shift && (len != '0) && (fill_p1 >= {1'b0, len})
            && ((win_nx & mask) == (pat & mask));
      len_clamp = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
   end

   assign cnt_sat = &match_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat       <= DEF_PATTERN;
         len       <= LW'(DEF_LEN);
         ovl       <= DEF_OVERLAP;
         win       <= '0;
         fill      <= '0;
         y         <= 1'b0;
         match_cnt <= '0;
      end else begin
         y <= hit;
         if (cfg_load) begin
            pat  <= cfg_pattern;
            len  <= len_clamp;
            ovl  <= cfg_overlap;
            win  <= '0;
            fill <= '0;
         end else if (x_valid) begin
            win <= win_nx;
            // Non-overlapping mode restarts the count so the next match needs fresh bits.
            if (hit && !ovl) begin
               fill <= '0;
            end else if (fill_p1 >= {1'b0, len}) begin
               fill <= len;
            end else begin
               fill <= fill_p1[LW-1:0];
            end
         end
         if (cnt_clr) begin
            match_cnt <= '0;
         end else if (hit && !cnt_sat) begin
            match_cnt <= match_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param
// Two instances (8-bit and 2-bit counters) share one stimulus stream.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_load, cfg_overlap, x_valid, x, cnt_clr;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       y8, y2, sat8, sat2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      bit y;
      int c8;
      int c2;
   } exp_t;
   exp_t exp_q[$];

   // reference model state: plain bit history instead of a window/fill pair
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   bit       hist[$];
   int       m_c8, m_c2;

   always #5 clk = ~clk;

   seq_detect_param dut8 (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
      .cnt_clr(cnt_clr), .y(y8), .match_cnt(cnt8), .cnt_sat(sat8)
   );

   seq_detect_param #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
      .cnt_clr(cnt_clr), .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pat = 8'b0001_1000;
      m_len = 5;
      m_ovl = 1'b0;
      hist.delete();
      m_c8 = 0;
      m_c2 = 0;
   endtask

   task automatic model_step(input bit v, input bit xb, input bit ld, input bit cl);
      exp_t e;
      bit   m;
      m = 1'b0;
      if (ld) begin
         m_pat = cfg_pattern;
         m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
         m_ovl = cfg_overlap;
         hist.delete();
      end else if (v) begin
         hist.push_back(xb);
         if (hist.size() > 16) void'(hist.pop_front());
         if (m_len > 0 && hist.size() >= m_len) begin
            m = 1'b1;
            for (int i = 0; i < m_len; i++)
               if (hist[hist.size() - 1 - i] != m_pat[i]) m = 1'b0;
         end
         if (m && !m_ovl) hist.delete();
      end
      if (cl) begin
         m_c8 = 0;
         m_c2 = 0;
      end else if (m) begin
         if (m_c8 < 255) m_c8++;
         if (m_c2 < 3) m_c2++;
      end
      e.y  = m;
      e.c8 = m_c8;
      e.c2 = m_c2;
      exp_q.push_back(e);
   endtask

   // drive at negedge, compare at the following negedge
   task automatic cyc(input bit v, input bit xb, input bit ld, input bit cl, input string tag);
      exp_t e;
      x_valid  = v;
      x        = xb;
      cfg_load = ld;
      cnt_clr  = cl;
      model_step(v, xb, ld, cl);
      @(posedge clk);
      @(negedge clk);
      x_valid  = 1'b0;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
      e = exp_q.pop_front();
      check({tag, "_y8"}, 32'(y8), 32'(e.y));
      check({tag, "_y2"}, 32'(y2), 32'(e.y));
      check({tag, "_cnt8"}, 32'(cnt8), e.c8);
      check({tag, "_cnt2"}, 32'(cnt2), e.c2);
      check({tag, "_sat8"}, 32'(sat8), 32'(e.c8 == 255));
      check({tag, "_sat2"}, 32'(sat2), 32'(e.c2 == 3));
   endtask

   task automatic send(input logic [15:0] bits, input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0, 1'b0, tag);
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o,
                       input bit v, input bit xb, input string tag);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      cyc(v, xb, 1'b1, 1'b0, tag);
   endtask

   initial begin
      rst_n = 1'b0;
      {cfg_load, cfg_overlap, x_valid, x, cnt_clr} = '0;
      cfg_pattern = '0;
      cfg_len     = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_y", 32'(y8), 0);
      check("rst_cnt", 32'(cnt8), 0);
      check("rst_sat", 32'(sat8), 0);
      rst_n = 1'b1;

      // defaults 11000, non-overlapping
      send(16'b11_0001_1000, 10, "t1");
      check("t1_total", 32'(cnt8), 2);

      // gap in the middle of a match
      send(16'b110, 3, "t3a");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "t3gap");
      send(16'b00, 2, "t3b");
      check("t3_total", 32'(cnt8), 3);

      // asynchronous reset between edges mid-pattern
      send(16'b1100, 4, "t4a");
      #2 rst_n = 1'b0;
      #1;
      check("t4_rst_y", 32'(y8), 0);
      check("t4_rst_cnt", 32'(cnt8), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send(16'b0, 1, "t4b");
      check("t4_total", 32'(cnt8), 0);

      // 1010 overlapping then non-overlapping
      load(8'b1010, 4'd4, 1'b1, 1'b0, 1'b0, "t2ld1");
      send(16'b10_1010, 6, "t2ov");
      check("t2_ov_total", 32'(cnt8), 2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "t2clr");
      load(8'b1010, 4'd4, 1'b0, 1'b0, 1'b0, "t2ld0");
      send(16'b10_1010, 6, "t2nov");
      check("t2_nov_total", 32'(cnt8), 1);

      // len 1, back-to-back matches
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "t5clr");
      load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0, "t5ld");
      send(16'b111, 3, "t5run");
      check("t5_total", 32'(cnt8), 3);
      // load coincident with a bit that would otherwise match
      load(8'b1, 4'd1, 1'b1, 1'b1, 1'b1, "t5coin");
      // len 0 disables detection
      load(8'b1, 4'd0, 1'b1, 1'b0, 1'b0, "t5len0");
      send(16'b1101, 4, "t5dis");
      check("t5_len0_total", 32'(cnt8), 3);
      // oversized length clamps to full width
      load(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0, "t5clamp");
      send(16'h0A5, 8, "t5cl");
      check("t5_clamp_total", 32'(cnt8), 4);

      // 2-bit counter saturation and clear-vs-match priority
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "t6clr");
      load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0, "t6ld");
      send(16'b11111, 5, "t6run");
      check("t6_cnt2", 32'(cnt2), 3);
      check("t6_sat2", 32'(sat2), 1);
      check("t6_cnt8", 32'(cnt8), 5);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t6clrhit");
      check("t6_clr_y", 32'(y2), 1);
      check("t6_clr_cnt", 32'(cnt2), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
